line_boundary_buffer: RTL and testbench

- Sits directly downstream of the Bresenham line generator and in parallel with the XY scan counter.
- Captures the generator's pixel stream into a per-row boundary table (minimum x per row).
- During display scan, it reads the table row-synchronously for the current y_cnt, compares against x_cnt, and drives the RGB outputs.
- This replaces the unsynchronised direct "x_cnt >= x_line" comparison with a frame-coherent half-plane fill.

---
 rtl/line_boundary_buffer_if.sv | 28 ++
 rtl/line_boundary_buffer.sv | 249 ++++++++++++++++++++++++
 tb/tb_line_boundary_buffer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_boundary_buffer_if.sv
// Pixel stream from the Bresenham line generator into the boundary buffer.
// The master is the generator; the slave is line_boundary_buffer.
interface line_boundary_buffer_if #(
    parameter int unsigned X_W = 11,
    parameter int unsigned Y_W = 10
);
    logic           pix_valid;
    logic           pix_ready;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           line_done;

    modport master (
        output pix_valid,
        output pix_x,
        output pix_y,
        output line_done,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        input  line_done,
        output pix_ready
    );
endinterface

// File: rtl/line_boundary_buffer.sv
// line_boundary_buffer: captures the line generator's pixel stream into a per-row
// table of minimum x, then colours the display scan as a frame-coherent half-plane
// fill (x >= row minimum). Rows the line never touched hold the all-ones sentinel
// and are treated as empty.
//
// Optional build macro LINE_BUF_MAXX_EN: adds a second per-row table holding the
// maximum x (sentinel 0), so only the drawn span row_min..row_max is coloured.
module line_boundary_buffer #(
    parameter int unsigned X_W    = 11,
    parameter int unsigned Y_W    = 10,
    parameter int unsigned ROWS   = 480,
    parameter logic [23:0] FG_RGB = 24'hDEDE00,
    parameter logic [23:0] BG_RGB = 24'h5646EF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    line_boundary_buffer_if.slave   pix,
    input  logic [X_W-1:0]          x_cnt,
    input  logic [Y_W-1:0]          y_cnt,
    output logic                    busy,
    output logic                    table_valid,
    output logic                    curseur,
    output logic [7:0]              red,
    output logic [7:0]              green,
    output logic [7:0]              blue
);

    localparam int unsigned    AW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [X_W-1:0] SENT_MIN = '1;
    localparam logic [X_W-1:0] SENT_MAX = '0;
    localparam logic [Y_W:0]   ROWS_Y   = ROWS[Y_W:0];
    localparam logic [AW-1:0]  LAST_ROW = AW'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StClear, StCapture} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  clr_ptr_q, clr_ptr_d;
    logic           table_valid_q, table_valid_d;
    logic           done_seen_q, done_seen_d;

    // Pending write stage of the capture read-modify-write
    logic           pend_q, pend_d;
    logic [AW-1:0]  pend_row_q, pend_row_d;
    logic [X_W-1:0] pend_x_q, pend_x_d;

    logic           ready;
    logic           accept;
    logic           in_range;
    logic [AW-1:0]  pix_row;
    logic [AW-1:0]  disp_row;

    // Minimum-x table, capture read data and display read data
    logic [X_W-1:0] min_mem [ROWS];
    logic [X_W-1:0] rd_min_q;
    logic [X_W-1:0] wr_min;
    logic [X_W-1:0] disp_min_q;

    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [X_W-1:0] mem_wmin;

    // Display pipeline
    logic [X_W-1:0] x_d_q;
    logic           y_ok_q;
    logic           pos;
    logic           curseur_q;
    logic [23:0]    rgb_q;

    assign pix_row  = pix.pix_y[AW-1:0];
    assign disp_row = y_cnt[AW-1:0];
    assign in_range = ({1'b0, pix.pix_y} < ROWS_Y);
    assign accept   = pix.pix_valid && ready;
    assign wr_min   = (rd_min_q < pend_x_q) ? rd_min_q : pend_x_q;

    assign pix.pix_ready = ready;
    assign table_valid   = table_valid_q;
    assign curseur       = curseur_q;
    assign red           = rgb_q[23:16];
    assign green         = rgb_q[15:8];
    assign blue          = rgb_q[7:0];

    // Control FSM next-state: clear sweep, capture, and start-abort handling
    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        table_valid_d = table_valid_q;
        done_seen_d   = done_seen_q;
        pend_d        = 1'b0;
        pend_row_d    = pend_row_q;
        pend_x_d      = pend_x_q;
        ready         = 1'b0;
        busy          = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StClear: begin
                busy      = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_ROW) begin
                    state_d   = StCapture;
                    clr_ptr_d = '0;
                end
            end
            StCapture: begin
                busy  = 1'b1;
                ready = 1'b1;
                // line_done may be a pulse; hold it until the pipeline drains
                if (pix.line_done) begin
                    done_seen_d = 1'b1;
                end
                // Out-of-range rows are accepted but never enter the write stage
                if (accept && in_range) begin
                    pend_d     = 1'b1;
                    pend_row_d = pix_row;
                    pend_x_d   = pix.pix_x;
                end
                if ((pix.line_done || done_seen_q) && !pend_q && !(accept && in_range)) begin
                    state_d       = StIdle;
                    table_valid_d = 1'b1;
                    done_seen_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start) begin
            state_d       = StClear;
            clr_ptr_d     = '0;
            table_valid_d = 1'b0;
            done_seen_d   = 1'b0;
            pend_d        = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            clr_ptr_q     <= '0;
            table_valid_q <= 1'b0;
            done_seen_q   <= 1'b0;
            pend_q        <= 1'b0;
            pend_row_q    <= '0;
            pend_x_q      <= '0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            table_valid_q <= table_valid_d;
            done_seen_q   <= done_seen_d;
            pend_q        <= pend_d;
            pend_row_q    <= pend_row_d;
            pend_x_q      <= pend_x_d;
        end
    end

    // Single write port shared by the clear sweep and the capture write stage
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = pend_row_q;
        mem_wmin  = wr_min;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wmin  = SENT_MIN;
        end else if (pend_q) begin
            mem_we = 1'b1;
        end
    end

    // Min table: write port, display read port (old data on same-row write)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            min_mem[mem_waddr] <= mem_wmin;
        end
        disp_min_q <= min_mem[disp_row];
    end

    // Capture read; a write landing on the same row this cycle is forwarded
    always_ff @(posedge clk) begin
        if (pend_q && (pend_row_q == pix_row)) begin
            rd_min_q <= wr_min;
        end else begin
            rd_min_q <= min_mem[pix_row];
        end
    end

`ifdef LINE_BUF_MAXX_EN
    logic [X_W-1:0] max_mem [ROWS];
    logic [X_W-1:0] rd_max_q;
    logic [X_W-1:0] wr_max;
    logic [X_W-1:0] disp_max_q;
    logic [X_W-1:0] mem_wmax;

    assign wr_max   = (rd_max_q > pend_x_q) ? rd_max_q : pend_x_q;
    assign mem_wmax = (state_q == StClear) ? SENT_MAX : wr_max;

    // Max table: same write/read timing as the min table
    always_ff @(posedge clk) begin
        if (mem_we) begin
            max_mem[mem_waddr] <= mem_wmax;
        end
        disp_max_q <= max_mem[disp_row];
    end

    // Capture read of the max table with the same forwarding
    always_ff @(posedge clk) begin
        if (pend_q && (pend_row_q == pix_row)) begin
            rd_max_q <= wr_max;
        end else begin
            rd_max_q <= max_mem[pix_row];
        end
    end

    // Only the drawn span of each row is inside the region
    assign pos = table_valid_q && y_ok_q && (disp_min_q != SENT_MIN) &&
                 (x_d_q >= disp_min_q) && (x_d_q <= disp_max_q);
`else
    // Half-plane fill; sentinel rows are empty so x=2047 never matches them
    assign pos = table_valid_q && y_ok_q && (disp_min_q != SENT_MIN) &&
                 (x_d_q >= disp_min_q);
`endif

    // Display stage 1: register scan position alongside the table read
    always_ff @(posedge clk) begin
        if (reset) begin
            x_d_q  <= '0;
            y_ok_q <= 1'b0;
        end else begin
            x_d_q  <= x_cnt;
            y_ok_q <= ({1'b0, y_cnt} < ROWS_Y);
        end
    end

    // Display stage 2: compare registered operands, register colour and flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q     <= BG_RGB;
            curseur_q <= 1'b0;
        end else begin
            rgb_q     <= pos ? FG_RGB : BG_RGB;
            curseur_q <= pos;
        end
    end

endmodule

// File: tb/tb_line_boundary_buffer.sv
// Directed bench for line_boundary_buffer: capture sequences driven by hand,
// display lookups applied from a table of {x, y, expected inside} records.
module tb_line_boundary_buffer;

    localparam logic [23:0] FG = 24'hDEDE00;
    localparam logic [23:0] BG = 24'h5646EF;
`ifdef LINE_BUF_MAXX_EN
    localparam bit MAXX = 1'b1;
`else
    localparam bit MAXX = 1'b0;
`endif

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        bit          fg;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic        busy;
    logic        table_valid;
    logic        curseur;
    logic [7:0]  red, green, blue;

    int checks;
    int errors;
    vec_t tbl[$];

    line_boundary_buffer_if #(.X_W(11), .Y_W(10)) pif ();

    line_boundary_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pix         (pif),
        .x_cnt       (x_cnt),
        .y_cnt       (y_cnt),
        .busy        (busy),
        .table_valid (table_valid),
        .curseur     (curseur),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int x, input int y, input bit fg);
        vec_t v;
        v.x = 11'(x);
        v.y = 10'(y);
        v.fg = fg;
        tbl.push_back(v);
    endtask

    // Present one scan position and check colour two cycles later
    task automatic scan(input string name, input logic [10:0] x, input logic [9:0] y,
                        input bit fg);
        x_cnt = x;
        y_cnt = y;
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("%s rgb y=%0d x=%0d", name, y, x), {red, green, blue}, fg ? FG : BG);
        check($sformatf("%s curseur y=%0d x=%0d", name, y, x), 32'(curseur), 32'(fg));
    endtask

    task automatic run_tbl(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            scan(name, tbl[i].x, tbl[i].y, tbl[i].fg);
        end
        tbl.delete();
    endtask

    // Pulse start, then measure how long the clear sweep keeps pix_ready low
    task automatic do_start(input string name);
        int n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, " table_valid after start"}, 32'(table_valid), 32'd0);
        check({name, " busy after start"}, 32'(busy), 32'd1);
        n = 0;
        while (!pif.pix_ready && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " clear cycles"}, n, 32'd480);
        check({name, " busy in capture"}, 32'(busy), 32'd1);
    endtask

    task automatic send(input int x, input int y, input bit done);
        pif.pix_valid = 1'b1;
        pif.pix_x     = 11'(x);
        pif.pix_y     = 10'(y);
        pif.line_done = done;
        @(posedge clk);
        #1;
        pif.pix_valid = 1'b0;
        pif.line_done = 1'b0;
    endtask

    task automatic finish_line(input string name, input bit pulse);
        int n;
        if (pulse) begin
            pif.line_done = 1'b1;
            @(posedge clk);
            #1;
            pif.line_done = 1'b0;
        end
        n = 0;
        while (!table_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " table_valid"}, 32'(table_valid), 32'd1);
        check({name, " busy idle"}, 32'(busy), 32'd0);
        check({name, " pix_ready idle"}, 32'(pif.pix_ready), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        x_cnt = '0;
        y_cnt = '0;
        pif.pix_valid = 1'b0;
        pif.pix_x = '0;
        pif.pix_y = '0;
        pif.line_done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset rgb", {red, green, blue}, BG);
        check("reset table_valid", 32'(table_valid), 32'd0);
        check("reset pix_ready", 32'(pif.pix_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset curseur", 32'(curseur), 32'd0);

        // Simple diagonal, line_done as a separate pulse
        do_start("t2");
        send(100, 0, 1'b0);
        send(101, 1, 1'b0);
        send(102, 2, 1'b0);
        finish_line("t3", 1'b1);
        add(100, 1, 0);
        add(101, 1, 1);
        add(0, 1, 0);
        add(99, 0, 0);
        add(100, 0, 1);
        add(101, 2, 0);
        add(102, 2, 1);
        add(2047, 2, !MAXX);
        add(500, 3, 0);
        add(2000, 600, 0);
        run_tbl("t3");

        // Latency: rgb must not change one cycle after x_cnt does
        x_cnt = 11'd100;
        y_cnt = 10'd1;
        repeat (3) @(posedge clk);
        #1;
        x_cnt = 11'd101;
        @(posedge clk);
        #1;
        check("lat cycle1 rgb", {red, green, blue}, BG);
        @(posedge clk);
        #1;
        check("lat cycle2 rgb", {red, green, blue}, FG);

        // Back-to-back same row, dropped out-of-range pixel, line_done with last pixel
        do_start("t4");
        send(50, 600, 1'b0);
        send(300, 5, 1'b0);
        send(250, 5, 1'b0);
        send(280, 5, 1'b1);
        finish_line("t4", 1'b0);
        add(249, 5, 0);
        add(250, 5, 1);
        add(280, 5, 1);
        add(300, 5, 1);
        add(301, 5, !MAXX);
        add(0, 10, 0);
        add(1024, 10, 0);
        add(2047, 10, 0);
        add(101, 1, 0);
        add(50, 88, 0);
        run_tbl("t4");

        // Abort mid-capture: the earlier pixel must be wiped by the restarted clear
        do_start("t5a");
        send(10, 3, 1'b0);
        send(11, 4, 1'b0);
        do_start("t5b");
        finish_line("t5", 1'b1);
        add(10, 3, 0);
        add(2047, 3, 0);
        add(2047, 4, 0);
        run_tbl("t5");

        // Span on one row (bounded only with the max table)
        do_start("t6");
        send(200, 7, 1'b0);
        send(210, 7, 1'b0);
        finish_line("t6", 1'b1);
        add(199, 7, 0);
        add(200, 7, 1);
        add(205, 7, 1);
        add(210, 7, 1);
        add(211, 7, !MAXX);
        run_tbl("t6");

        // Reset wins over a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("rst+start busy", 32'(busy), 32'd0);
        check("rst+start table_valid", 32'(table_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rst+start busy later", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
